// File: rtl/alu_seq.sv
// WIDTH-bit execute-stage ALU: logic/add/sub/slt complete in one registered cycle, unsigned MUL by
// iterative shift-add over WIDTH cycles; busy holds off new starts (ignored, not queued), done pulses once per op.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carryout,
   output logic             o_overflow,
   output logic             o_zero
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_breg;
   logic [CNTW-1:0]    r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_ovf;
   logic               r_zero;
   logic               r_done;

   // Shared adder: SUB and SLT both compute a + ~b + 1.
   logic               w_sub;
   logic [WIDTH-1:0]   w_b_eff;
   logic [WIDTH:0]     w_sum_full;
   logic               w_cout;
   logic               w_cin_msb;
   logic               w_ovf;

   assign w_sub      = (i_op == OP_SUB) || (i_op == OP_SLT);
   assign w_b_eff    = w_sub ? ~i_b : i_b;
   assign w_sum_full = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
   assign w_cout     = w_sum_full[WIDTH];
   assign w_cin_msb  = i_a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum_full[WIDTH-1];
   assign w_ovf      = w_cin_msb ^ w_cout;

   logic [WIDTH-1:0]   w_alu_res;
   logic               w_alu_cy;
   logic               w_alu_ov;

   always_comb begin
      w_alu_res = '0;
      w_alu_cy  = 1'b0;
      w_alu_ov  = 1'b0;
      case (i_op)
         OP_AND: w_alu_res = i_a & i_b;
         OP_OR:  w_alu_res = i_a | i_b;
         OP_NOR: w_alu_res = ~(i_a | i_b);
         OP_XOR: w_alu_res = i_a ^ i_b;
         OP_ADD, OP_SUB: begin
            w_alu_res = w_sum_full[WIDTH-1:0];
            w_alu_cy  = w_cout;
            w_alu_ov  = w_ovf;
         end
         OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_sum_full[WIDTH-1] ^ w_ovf};
         default: ;
      endcase
   end

   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [CNTW-1:0]    w_cnt_nxt;
   logic               w_mul_last;

   assign w_acc_nxt  = r_breg[0] ? (r_acc + r_mcand) : r_acc;
   assign w_cnt_nxt  = r_cnt + CNTW'(1);
   assign w_mul_last = (w_cnt_nxt == CNTW'(WIDTH));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start && (i_op == OP_MUL)) w_state_nxt = S_MUL;
         S_MUL:   if (w_mul_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_breg   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start && (i_op == OP_MUL)) begin
                  r_acc   <= '0;
                  r_mcand <= {{WIDTH{1'b0}}, i_a};
                  r_breg  <= i_b;
                  r_cnt   <= '0;
               end else if (i_start) begin
                  r_result <= w_alu_res;
                  r_carry  <= w_alu_cy;
                  r_ovf    <= w_alu_ov;
                  r_zero   <= (w_alu_res == '0);
                  r_done   <= 1'b1;
               end
            end
            S_MUL: begin
               r_acc   <= w_acc_nxt;
               r_mcand <= r_mcand << 1;
               r_breg  <= r_breg >> 1;
               r_cnt   <= w_cnt_nxt;
               // Final iteration: publish the product including this edge's partial sum.
               if (w_mul_last) begin
                  r_result <= w_acc_nxt[WIDTH-1:0];
                  r_carry  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                  r_ovf    <= 1'b0;
                  r_zero   <= (w_acc_nxt[WIDTH-1:0] == '0);
                  r_done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy     = (r_state == S_MUL);
   assign o_done     = r_done;
   assign o_result   = r_result;
   assign o_carryout = r_carry;
   assign o_overflow = r_ovf;
   assign o_zero     = r_zero;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit datapath ALU; successor to the per-bit ALU slices.
- Executes AND/OR/XOR/NOR/ADD/SUB/SLT in one registered cycle.
- Executes unsigned MUL as an iterative shift-add over WIDTH cycles.
- Uses a start/busy/done handshake. Sits in the execute stage; the control unit stalls on busy.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNTW, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled on rising edge when busy=0
- op  in  3  operation code, captured with start
- a  in  WIDTH  operand A, captured with start
- b  in  WIDTH  operand B, captured with start
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  registered result
- carryout  out  1  registered carry flag
- overflow  out  1  registered signed-overflow flag
- zero  out  1  registered, result==0

Behaviour:
- Reset (sync, active-high): busy=0, done=0, result=0, carryout=0, overflow=0, zero=0. FSM goes to IDLE, counter=0. Reset has priority over start and aborts a MUL in progress; no done is generated for the aborted op.
- Op codes:
  - 000 AND: a&b
  - 001 OR: a|b
  - 010 ADD: a+b
  - 011 MUL: low WIDTH bits of unsigned a*b
  - 100 NOR: ~(a|b)
  - 101 XOR: a^b
  - 110 SUB: a+~b+1
  - 111 SLT: signed a<b → {0…,1} or 0
- FSM states: IDLE, MUL.
  - IDLE, start=1, op!=011: at that edge, result/flags are written, done=1 for the next cycle, busy stays 0. Latency 1.
  - IDLE, start=1, op=011: capture a, b; clear the 2*WIDTH accumulator; counter=0; busy=1; go to MUL.
  - MUL, each edge: if breg[0], acc+=mcand; mcand<<=1; breg>>=1; counter++.
  - MUL exit: on the edge where counter reaches WIDTH, write result=acc[WIDTH-1:0] and flags, busy=0, done=1, go to IDLE. Start sampled at edge k gives done high in the cycle after edge k+WIDTH.
  - start while busy=1 is ignored (not queued).
  - Back-to-back start on the cycle done=1 is accepted.
- done is high exactly one cycle per completed op and low otherwise. result and flags hold until the next completion or reset.
- Flags:
  - ADD/SUB: carryout = carry out of the MSB of the WIDTH-bit adder (SUB: 1 = no borrow). overflow = carry into MSB XOR carry out of MSB.
  - SLT: result[0] = sum[MSB] XOR overflow of a-b; carryout=0, overflow=0.
  - Logic ops: carryout=0, overflow=0.
  - MUL: carryout = |acc[2*WIDTH-1:WIDTH] (product truncated); overflow=0.
  - zero is computed from the new result in all ops.
- op/a/b changes after capture have no effect on an in-flight MUL.
- No combinational path from inputs to outputs.

Test Plan (WIDTH=16):
- Reset, then ADD a=0x7FFF b=0x0001 → after 1 edge: result=0x8000, overflow=1, carryout=0, zero=0, done=1 for one cycle, busy never 1.
- SUB a=0x0005 b=0x0005 → result=0x0000, zero=1, carryout=1, overflow=0. SUB a=0x0000 b=0x0001 → result=0xFFFF, carryout=0.
- SLT a=0xFFFD b=0x0002 → result=0x0001. SLT a=0x7FFF b=0x8000 → 0x0000. SLT a=0x8000 b=0x7FFF (overflow case) → 0x0001.
- MUL a=0x0012 b=0x0034 → busy=1 for 16 cycles, done pulses the cycle after the 16th iteration edge, result=0x03A8, carryout=0. MUL a=0x0100 b=0x0100 → result=0x0000, zero=1, carryout=1.
- During MUL, pulse start with op=000 a=0xFFFF b=0xFFFF → ignored. MUL result unchanged and a single done is seen. Issue ADD on the done cycle → accepted, completes next cycle.
- Assert reset at the 8th MUL iteration → next cycle busy=0, done=0, result=0 and all flags 0. No done follows. A new MUL then completes correctly.
